// File: rtl/dump_pkg.sv
// Shared constants for the capture/dump serial stream: header label, frame
// geometry and the receive FSM state encoding.
package dump_pkg;

    localparam logic [7:0] DUMP_LABEL        = 8'hF0;
    localparam int         DUMP_NUM_CH       = 8;
    localparam int         DUMP_BYTES_PER_CH = 16;
    localparam int         DUMP_TIMEOUT_CYC  = 100000;

    localparam logic [2:0] ST_HUNT = 3'd0;
    localparam logic [2:0] ST_H1   = 3'd1;
    localparam logic [2:0] ST_NUM  = 3'd2;
    localparam logic [2:0] ST_H3   = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;

    // A dump number byte carries the number in the low nibble only.
    function automatic logic is_num_byte(input logic [7:0] b);
        return (b[7:4] == 4'h0);
    endfunction

    function automatic logic [3:0] next_num(input logic [3:0] n);
        return n + 4'd1;
    endfunction

endpackage

// File: rtl/dump_rx_timeout.sv
// Idle-cycle watchdog for serial receivers: counts while run_i is high,
// clears on clr_i, can be preloaded, and pulses tc_o at TIMEOUT_CYC-1.
module dump_rx_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic [((TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1)-1:0] load_val_i,
    output logic tc_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A clear in the terminal cycle suppresses the pulse: fresh activity wins.
    assign tc_o = run_i && !clr_i && !load_i && (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || clr_i || tc_o) cnt_d = '0;
        else if (load_i)             cnt_d = load_val_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dump_frame_rx.sv
// Host-side dump stream decoder: locks on LABEL LABEL NN LABEL and maps data
// bytes to channel/index. Optional DUMP_SEQ_CHECK_EN adds seq_err.
module dump_frame_rx
    import dump_pkg::*;
#(
    parameter logic [7:0] LABEL        = DUMP_LABEL,
    parameter int         NUM_CH       = DUMP_NUM_CH,
    parameter int         BYTES_PER_CH = DUMP_BYTES_PER_CH,
    parameter int         TIMEOUT_CYC  = DUMP_TIMEOUT_CYC
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_vld,
    output logic                            out_vld,
    output logic [7:0]                      out_data,
    output logic [$clog2(NUM_CH)-1:0]       out_ch,
    output logic [$clog2(BYTES_PER_CH)-1:0] out_idx,
    output logic [3:0]                      frame_num,
    output logic                            frame_done,
    output logic                            hdr_err,
    output logic                            tmo_err,
    output logic [3:0]                      frames_rx
`ifdef DUMP_SEQ_CHECK_EN
    ,
    output logic                            seq_err
`endif
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IDX_W = $clog2(BYTES_PER_CH);
    localparam int BC_W  = CH_W + IDX_W;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_CH * BYTES_PER_CH - 1);
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [2:0]       state_q, state_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic             out_vld_q;
    logic [7:0]       out_data_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [3:0]       frame_num_q;
    logic             done_pend_q, frame_done_q;
    logic             hdr_err_q, tmo_err_q;
    logic [3:0]       frames_rx_q;

    logic hdr_err_d, emit, last, num_ok, tmo_tc;

    dump_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q != ST_HUNT),
        .clr_i      (rx_vld),
        .load_i     (1'b0),
        .load_val_i ({TMO_W{1'b0}}),
        .tc_o       (tmo_tc)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        hdr_err_d  = 1'b0;
        emit       = 1'b0;
        last       = 1'b0;
        num_ok     = 1'b0;
        if (tmo_tc) begin
            state_d = ST_HUNT;
        end else if (rx_vld) begin
            case (state_q)
                ST_HUNT: if (rx_data == LABEL) state_d = ST_H1;
                ST_H1: begin
                    if (rx_data == LABEL) state_d = ST_NUM;
                    else begin
                        hdr_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
                ST_NUM: begin
                    if (is_num_byte(rx_data)) begin
                        num_ok  = 1'b1;
                        state_d = ST_H3;
                    end else begin
                        // A label here may be the start of a real header.
                        hdr_err_d = 1'b1;
                        state_d   = (rx_data == LABEL) ? ST_H1 : ST_HUNT;
                    end
                end
                ST_H3: begin
                    if (rx_data == LABEL) begin
                        state_d    = ST_DATA;
                        byte_cnt_d = '0;
                    end else begin
                        hdr_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
                ST_DATA: begin
                    emit       = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        last    = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            byte_cnt_q   <= '0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_idx_q    <= '0;
            frame_num_q  <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            hdr_err_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
            frames_rx_q  <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            out_vld_q    <= emit;
            hdr_err_q    <= hdr_err_d;
            tmo_err_q    <= tmo_tc;
            done_pend_q  <= last;
            // frame_done lands one cycle after the final out_vld.
            frame_done_q <= done_pend_q;
            if (emit) begin
                out_data_q <= rx_data;
                out_ch_q   <= byte_cnt_q[CH_W-1:0];
                out_idx_q  <= byte_cnt_q[CH_W +: IDX_W];
            end
            if (num_ok) frame_num_q <= rx_data[3:0];
            if (done_pend_q && frames_rx_q != 4'hF) frames_rx_q <= frames_rx_q + 4'd1;
        end
    end

`ifdef DUMP_SEQ_CHECK_EN
    logic [3:0] ref_q;
    logic       ref_vld_q, seq_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= num_ok && ref_vld_q && (rx_data[3:0] != next_num(ref_q));
            // Only completed frames advance the reference.
            if (last) begin
                ref_q     <= frame_num_q;
                ref_vld_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`endif

    assign out_vld    = out_vld_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_idx    = out_idx_q;
    assign frame_num  = frame_num_q;
    assign frame_done = frame_done_q;
    assign hdr_err    = hdr_err_q;
    assign tmo_err    = tmo_err_q;
    assign frames_rx  = frames_rx_q;

endmodule

// File: tb/tb_dump_frame_rx.sv
// Scoreboard bench for dump_frame_rx: directed frames, noise, resync,
// timeout, back-to-back, saturation and mid-frame reset.
module tb_dump_frame_rx;

    localparam int NB  = 128;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld = 1'b0;
    logic       out_vld, frame_done, hdr_err, tmo_err;
    logic [7:0] out_data;
    logic [2:0] out_ch;
    logic [3:0] out_idx, frame_num, frames_rx;
`ifdef DUMP_SEQ_CHECK_EN
    logic       seq_err;
`endif

    dump_frame_rx #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
        .out_vld(out_vld), .out_data(out_data), .out_ch(out_ch), .out_idx(out_idx),
        .frame_num(frame_num), .frame_done(frame_done), .hdr_err(hdr_err),
        .tmo_err(tmo_err), .frames_rx(frames_rx)
`ifdef DUMP_SEQ_CHECK_EN
        , .seq_err(seq_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] ch;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;
    int cyc = 0, last_vld_cyc = -10;
    int done_cnt = 0, hdr_cnt = 0, tmo_cnt = 0, seq_cnt = 0;
    int b_done, b_hdr, b_tmo, b_seq;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every decoded byte and tallies pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                last_vld_cyc = cyc;
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_byte", int'({out_data, out_ch, out_idx}), int'(e));
                end
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_latency", cyc - last_vld_cyc, 1);
                chk("done_sb_empty", sb.size(), 0);
            end
            if (hdr_err) hdr_cnt++;
            if (tmo_err) tmo_cnt++;
            if ((hdr_err && tmo_err) || (frame_done && (hdr_err || tmo_err)))
                chk("pulse_overlap", 1, 0);
`ifdef DUMP_SEQ_CHECK_EN
            if (seq_err) seq_cnt++;
`endif
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_vld  = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            rx_vld = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_vld = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [3:0] nn, input int gap);
        send(8'hF0, gap);
        send(8'hF0, gap);
        send({4'h0, nn}, gap);
        send(8'hF0, gap);
    endtask

    // k<0 sends 00..n-1, otherwise a scrambled pattern that hits 0xF0 too.
    task automatic send_data(input int n, input int k, input int gap);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = (k < 0) ? 8'(i) : 8'(i * 7 + k);
            sb.push_back({d, 3'(i % 8), 4'(i / 8)});
            send(d, gap);
        end
    endtask

    task automatic mark();
        b_done = done_cnt; b_hdr = hdr_cnt; b_tmo = tmo_cnt; b_seq = seq_cnt;
    endtask

    task automatic finish_scn(input string s, input int ed, input int eh, input int et,
                              input int es, input int efr, input int enum_);
        idle(5);
        chk({s, "_done"}, done_cnt - b_done, ed);
        chk({s, "_hdr"}, hdr_cnt - b_hdr, eh);
        chk({s, "_tmo"}, tmo_cnt - b_tmo, et);
        chk({s, "_frames_rx"}, int'(frames_rx), efr);
        chk({s, "_frame_num"}, int'(frame_num), enum_);
        chk({s, "_sb_left"}, sb.size(), 0);
`ifdef DUMP_SEQ_CHECK_EN
        chk({s, "_seq"}, seq_cnt - b_seq, es);
`else
        if (es < 0) chk({s, "_seq_arg"}, es, 0);
`endif
        mark();
    endtask

    initial begin
        idle(3);
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_frame_num", int'(frame_num), 0);
        chk("rst_frames_rx", int'(frames_rx), 0);
        chk("rst_pulses", int'({frame_done, hdr_err, tmo_err}), 0);
        rst_n = 1'b1;
        idle(2);
        mark();

        send_hdr(4'h3, 1); send_data(NB, -1, 1);
        finish_scn("basic", 1, 0, 0, 0, 1, 3);

        send(8'h55, 1); send(8'hAA, 1);
        send_hdr(4'h5, 2); send_data(NB, 11, 2);
        finish_scn("noise", 1, 0, 0, 1, 2, 5);

        send(8'hF0, 0); send(8'hF0, 0);
        send_hdr(4'h5, 0); send_data(NB, 200, 1);
        finish_scn("resync", 1, 1, 0, 1, 3, 5);

        send_hdr(4'h2, 1); send_data(10, 3, 1);
        idle(TMO + 10);
        finish_scn("timeout", 0, 0, 1, 1, 3, 2);

        send_hdr(4'h6, 1); send_data(NB, 90, 1);
        finish_scn("post_tmo", 1, 0, 0, 0, 4, 6);

        send_hdr(4'h0, 0); send_data(NB, 17, 0);
        finish_scn("b2b", 1, 0, 0, 1, 5, 0);

        send_hdr(4'h1, 0); send_data(NB, 1, 0);
        finish_scn("seq1", 1, 0, 0, 0, 6, 1);
        send_hdr(4'h2, 0); send_data(NB, 2, 0);
        finish_scn("seq2", 1, 0, 0, 0, 7, 2);
        send_hdr(4'h4, 0); send_data(NB, 4, 0);
        finish_scn("seq4", 1, 0, 0, 1, 8, 4);

        for (int f = 5; f < 13; f++) begin
            send_hdr(4'(f), 0); send_data(NB, f, 0);
        end
        finish_scn("saturate", 8, 0, 0, 0, 15, 12);

        send_hdr(4'h7, 1); send_data(5, 33, 1);
        idle(3);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        chk("midrst_frames_rx", int'(frames_rx), 0);
        chk("midrst_frame_num", int'(frame_num), 0);
        chk("midrst_out_vld", int'(out_vld), 0);
        rst_n = 1'b1;
        idle(2);
        mark();
        send_hdr(4'h9, 0); send_data(NB, 55, 0);
        finish_scn("after_rst", 1, 0, 0, 0, 1, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
